// File: rtl/cmos_clk_pkg.sv
// Shared state encoding, output decode and default parameters for the PLL supervisor.
// Optional relock counter is enabled with the CMOS_PLL_RELOCK_CNT_EN macro.
package cmos_clk_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_FAIL
    } chan_state_t;

    typedef struct packed {
        logic rst;
        logic ok;
        logic fail;
    } chan_out_t;

    localparam int DEF_NUM_PLL       = 2;
    localparam int DEF_RST_CYCLES    = 100;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 5000;
    localparam int DEF_MAX_RETRY     = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic chan_out_t decode(input chan_state_t st);
        chan_out_t o;
        o = '{rst: 1'b0, ok: 1'b0, fail: 1'b0};
        case (st)
            ST_HOLD:   o.rst = 1'b1;
            ST_LOCKED: o.ok  = 1'b1;
            ST_FAIL: begin
                o.rst  = 1'b1;
                o.fail = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cmos_pll_chan.sv
// One supervised PLL channel: lock synchroniser, sequencing FSM, cycle and retry counters.
// CMOS_PLL_RELOCK_CNT_EN adds a saturating count of lock losses seen in LOCKED.
//
// state        | meaning
// ST_HOLD      | PLL held in reset for RST_CYCLES
// ST_WAIT_LOCK | reset released, waiting up to LOCK_TIMEOUT for lock
// ST_STABLE    | lock seen, must hold for STABLE_CYCLES
// ST_LOCKED    | channel ok, watching for lock loss
// ST_FAIL      | retries exhausted, PLL held in reset until restart
module cmos_pll_chan
    import cmos_clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       pll_ok,
    output logic       pll_fail
`ifdef CMOS_PLL_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_cnt
`endif
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRY);

    logic             lock_m;
    logic             lock_s;
    chan_state_t      state;
    chan_state_t      retry_state;
    chan_out_t        outs;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] rty;
    logic [RTY_W-1:0] rty_inc;

    // Saturating increment keeps retry-forever mode (MAX_RETRY==0) from wrapping.
    assign rty_inc     = (&rty) ? rty : rty + RTY_W'(1);
    assign retry_state = ((MAX_RETRY != 0) && (rty_inc == RTY_LIMIT)) ? ST_FAIL : ST_HOLD;

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset || restart) begin
            state <= ST_HOLD;
            outs  <= decode(ST_HOLD);
            cnt   <= '0;
            rty   <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        state <= ST_WAIT_LOCK;
                        outs  <= decode(ST_WAIT_LOCK);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        outs  <= decode(ST_STABLE);
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state <= retry_state;
                        outs  <= decode(retry_state);
                        cnt   <= '0;
                        rty   <= rty_inc;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= retry_state;
                        outs  <= decode(retry_state);
                        cnt   <= '0;
                        rty   <= rty_inc;
                    end else if (cnt == STABLE_LAST) begin
                        state <= ST_LOCKED;
                        outs  <= decode(ST_LOCKED);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Losing lock after a good lock is a fresh start, not a retry.
                    if (!lock_s) begin
                        state <= ST_HOLD;
                        outs  <= decode(ST_HOLD);
                        cnt   <= '0;
                        rty   <= '0;
                    end
                end
                ST_FAIL: ;
                default: begin
                    state <= ST_HOLD;
                    outs  <= decode(ST_HOLD);
                    cnt   <= '0;
                    rty   <= '0;
                end
            endcase
        end
    end

`ifdef CMOS_PLL_RELOCK_CNT_EN
    always_ff @(posedge clkin) begin
        if (reset) begin
            relock_cnt <= '0;
        end else if (!restart && state == ST_LOCKED && !lock_s && relock_cnt != 8'hFF) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end
`endif

    assign pll_reset = outs.rst;
    assign pll_ok    = outs.ok;
    assign pll_fail  = outs.fail;

endmodule

// File: rtl/cmos_pll_supervisor.sv
// Supervisor for NUM_PLL independent PLL channels plus a combined all_ok flag.
// CMOS_PLL_RELOCK_CNT_EN exposes per-channel 8-bit lock-loss counters on relock_cnt.
module cmos_pll_supervisor
    import cmos_clk_pkg::*;
#(
    parameter int NUM_PLL       = DEF_NUM_PLL,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic [NUM_PLL-1:0]   pll_lock,
    input  logic [NUM_PLL-1:0]   restart,
    output logic [NUM_PLL-1:0]   pll_reset,
    output logic [NUM_PLL-1:0]   pll_ok,
    output logic [NUM_PLL-1:0]   pll_fail,
    output logic                 all_ok
`ifdef CMOS_PLL_RELOCK_CNT_EN
    ,
    output logic [NUM_PLL*8-1:0] relock_cnt
`endif
);

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_chan
        cmos_pll_chan #(
            .RST_CYCLES   (RST_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_RETRY    (MAX_RETRY)
        ) u_chan (
            .clkin     (clkin),
            .reset     (reset),
            .pll_lock  (pll_lock[i]),
            .restart   (restart[i]),
            .pll_reset (pll_reset[i]),
            .pll_ok    (pll_ok[i]),
            .pll_fail  (pll_fail[i])
`ifdef CMOS_PLL_RELOCK_CNT_EN
            ,
            .relock_cnt(relock_cnt[i*8 +: 8])
`endif
        );
    end

    assign all_ok = &pll_ok;

endmodule
